// File: rtl/wire_cmd_sampler.sv
// rtl/wire_cmd_sampler.sv - Wire In toggle-handshake command sampler with FWFT command FIFO
// Optional feature macro: WIRE_CMD_STATS_EN adds the stat_accepted counter port.
module wire_cmd_sampler #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   wire_in,
    output logic [30:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   count,
`ifdef WIRE_CMD_STATS_EN
    output logic [15:0]   stat_accepted,
`endif
    output logic [31:0]   ack_out
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SETTLE     = 2'd1,
        WAIT_SPACE = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    logic          tog_seen;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [30:0]   mem [DEPTH];

    logic          pending;
    logic          full;
    logic          push;
    logic          pop;
    logic [AW:0]   cnt_next;
    logic          tog_next;

    // Handshake qualifiers derived from registered state only, so a pop
    // in the current cycle can never open space for a push in the same cycle.
    always_comb begin
        pending = (wire_in[31] != tog_seen);
        full    = (count == FULL_CNT);
        pop     = dout_valid && dout_ready;
        push    = 1'b0;
        case (state)
            SETTLE:     push = pending && !full;
            WAIT_SPACE: push = !full;
            default:    push = 1'b0;
        endcase
    end

    // Next occupancy and next acknowledged toggle, shared by the count and
    // ack_out registers so the status word tracks them on the same edge.
    always_comb begin
        cnt_next = count;
        if (push && !pop) begin
            cnt_next = count + CNT_ONE;
        end else if (pop && !push) begin
            cnt_next = count - CNT_ONE;
        end
        tog_next = push ? wire_in[31] : tog_seen;
    end

    // Command sampling FSM: one settle cycle filters toggle glitches, then
    // the command is pushed or held until the FIFO has room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tog_seen <= 1'b0;
        end else begin
            tog_seen <= tog_next;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!pending) begin
                        state <= IDLE;
                    end else if (!full) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (!full) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered Wire Out status word;
    // reset discards every buffered command at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ack_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= cnt_next;
            ack_out <= {tog_next, 15'b0, 16'(cnt_next)};
        end
    end

    // Payload storage; the payload is taken from the wire in the push cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wire_in[30:0];
        end
    end

`ifdef WIRE_CMD_STATS_EN
    // Accepted-command counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_accepted <= '0;
        end else if (push) begin
            stat_accepted <= stat_accepted + 16'd1;
        end
    end
`endif

    // First-word fall-through head of the FIFO.
    always_comb begin
        dout       = mem[rd_ptr];
        dout_valid = (count != '0);
    end

endmodule

// File: tb/tb_wire_cmd_sampler.sv
// tb/tb_wire_cmd_sampler.sv - directed self-checking bench for wire_cmd_sampler
module tb_wire_cmd_sampler;

    logic        clk;
    logic        reset;
    logic [31:0] wire_in;
    logic [30:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [3:0]  count;
    logic [31:0] ack_out;
`ifdef WIRE_CMD_STATS_EN
    logic [15:0] stat_accepted;
`endif

    int checks = 0;
    int errors = 0;
    logic host_tog;

    wire_cmd_sampler #(.DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .wire_in      (wire_in),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .count        (count),
`ifdef WIRE_CMD_STATS_EN
        .stat_accepted(stat_accepted),
`endif
        .ack_out      (ack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host side: flip toggle with payload, then wait (bounded) for the ack.
    task automatic send_cmd(input logic [30:0] p);
        bit seen;
        seen = 1'b0;
        host_tog = ~host_tog;
        wire_in  = {host_tog, p};
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_out[31] == host_tog) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("ack_wait", {31'b0, ack_out[31]}, {31'b0, host_tog});
        end
    endtask

    initial begin
        reset      = 1'b1;
        wire_in    = 32'h0;
        dout_ready = 1'b0;
        host_tog   = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_ack", ack_out, 32'h0);
`ifdef WIRE_CMD_STATS_EN
        check("rst_stat", 32'(stat_accepted), 32'd0);
`endif
        #20;
        reset = 1'b0;
        tick();

        // Toggle glitch 0->1->0: filtered by the settle cycle
        wire_in = 32'h8000_0055;
        tick();
        wire_in = 32'h0000_0055;
        tick();
        tick();
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_ack", ack_out, 32'h0);

        // Single command: push two edges after the toggle
        wire_in = 32'h8000_1234;
        host_tog = 1'b1;
        tick();
        check("single_n_count", 32'(count), 32'd0);
        tick();
        check("single_dout", 32'(dout), 32'h1234);
        check("single_valid", 32'(dout_valid), 32'd1);
        check("single_ack", ack_out, 32'h8000_0001);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("single_pop_count", 32'(count), 32'd0);
        check("single_pop_ack", ack_out, 32'h8000_0000);
        check("single_pop_valid", 32'(dout_valid), 32'd0);

        // Full FIFO: 8 accepted, 9th held until a pop
        for (int i = 0; i < 8; i++) send_cmd(31'(100 + i));
        check("full_count", 32'(count), 32'd8);
        check("full_ack", ack_out, 32'h8000_0008);
        host_tog = 1'b0;
        wire_in  = {1'b0, 31'd200};
        for (int i = 0; i < 5; i++) tick();
        check("held_ack", ack_out, 32'h8000_0008);
        check("held_count", 32'(count), 32'd8);
        check("held_head", 32'(dout), 32'd100);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("held_pop_count", 32'(count), 32'd7);
        check("held_pop_ack", ack_out, 32'h8000_0007);
        tick();
        check("late_push_count", 32'(count), 32'd8);
        check("late_push_ack", ack_out, 32'h0000_0008);
        dout_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("full_drain", 32'(dout), 32'(101 + i));
            tick();
        end
        check("full_drain_last", 32'(dout), 32'd200);
        tick();
        dout_ready = 1'b0;
        check("full_drain_count", 32'(count), 32'd0);
        check("full_drain_ack", ack_out, 32'h0000_0000);

        // Simultaneous push and pop at count 3
        send_cmd(31'd300);
        send_cmd(31'd301);
        send_cmd(31'd302);
        check("sim_pre_count", 32'(count), 32'd3);
        host_tog = 1'b0;
        wire_in  = {1'b0, 31'd303};
        tick();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("sim_count", 32'(count), 32'd3);
        check("sim_ack", ack_out, 32'h0000_0003);
        dout_ready = 1'b1;
        check("sim_order0", 32'(dout), 32'd301);
        tick();
        check("sim_order1", 32'(dout), 32'd302);
        tick();
        check("sim_order2", 32'(dout), 32'd303);
        tick();
        dout_ready = 1'b0;
        check("sim_empty", 32'(dout_valid), 32'd0);

        // Pointer wrap: fresh reset, 20 commands streamed with dout_ready high
        reset    = 1'b1;
        wire_in  = 32'h0;
        host_tog = 1'b0;
        #3;
        reset = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_cmd(31'(i));
            check("wrap_dout", 32'(dout), 32'(i));
        end
`ifdef WIRE_CMD_STATS_EN
        check("wrap_stat", 32'(stat_accepted), 32'd20);
`endif
        tick();
        dout_ready = 1'b0;
        check("wrap_empty", 32'(count), 32'd0);

        // Reset mid-operation with count 5 and toggle high
        for (int i = 0; i < 5; i++) send_cmd(31'(500 + i));
        check("mid_pre_count", 32'(count), 32'd5);
        check("mid_pre_tog", 32'(wire_in[31]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_ack", ack_out, 32'h0);
`ifdef WIRE_CMD_STATS_EN
        check("mid_rst_stat", 32'(stat_accepted), 32'd0);
`endif
        #3;
        reset = 1'b0;
        tick();
        check("post_rst_n_count", 32'(count), 32'd0);
        tick();
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_dout", 32'(dout), 32'd504);
        check("post_rst_ack", ack_out, 32'h8000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wire_cmd_sampler.md
# wire_cmd_sampler

Converts host commands delivered through a 32-bit Wire In endpoint into a ready/valid command stream for user logic. Sits directly downstream of the Wire In endpoint in the okClk domain. A toggle bit handshakes each command with the host. Commands are buffered in a small FIFO, and a status word for a Wire Out endpoint reports the acknowledged toggle and the FIFO occupancy.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2
- AW, 3, log2(DEPTH)

Ports:
- clk  input  1  okClk; all logic is on the rising edge
- reset  input  1  asynchronous, active-high
- wire_in  input  32  Wire In endpoint value; [31] is the command toggle, [30:0] is the payload
- dout  output  31  head-of-FIFO payload
- dout_valid  output  1  high when the FIFO is not empty
- dout_ready  input  1  consumer accepts the head entry when dout_valid and dout_ready are both high
- count  output  AW+1  FIFO occupancy, 0..DEPTH
- ack_out  output  32  Wire Out status: {tog_seen, 15'b0, 16-bit zero-extended count}
- stat_accepted  output  16  number of commands accepted; present only with WIRE_CMD_STATS_EN

## Operation
- tog_seen register holds the toggle value of the last accepted command. Reset value is 0.
- A new command is pending when wire_in[31] != tog_seen.
- Host protocol:
  - write the payload and the flipped toggle in one wire update;
  - do not write again until ack_out[31] equals the toggle just written.
- FSM states:
  - IDLE: if pending, go to SETTLE.
  - SETTLE: the wire has been stable for one cycle.
    - If not pending (toggle reverted): go to IDLE, no push.
    - If pending and count < DEPTH: push wire_in[30:0], set tog_seen <= wire_in[31], go to IDLE.
    - If pending and full: go to WAIT_SPACE.
  - WAIT_SPACE: push and return to IDLE on the first cycle with count < DEPTH. Payload is sampled from wire_in in the push cycle.
- FIFO:
  - circular, with AW-bit read/write pointers that wrap modulo DEPTH;
  - count is a separate (AW+1)-bit register;
  - first-word fall-through: dout = mem[rd_ptr], dout_valid = (count != 0).
- A pop occurs when dout_valid && dout_ready. Simultaneous push and pop leaves count unchanged and advances both pointers.
- A push is never issued while count == DEPTH. A pop in the same cycle does not enable a push; the push follows on the next cycle.
- dout_ready while empty has no effect.
- Commands are never dropped. Back-pressure reaches the host only through a withheld ack.

## Timing
- Reset values:
  - FSM = IDLE
  - pointers = 0, count = 0
  - tog_seen = 0
  - dout_valid = 0
  - ack_out = 0
  - stat_accepted = 0
  - dout is don't-care while dout_valid = 0
- Reset asserted mid-operation: all buffered commands are discarded immediately (asynchronously).
  - After reset, wire_in[31] = 1 counts as a new command. The Wire In endpoint also clears to 0 on host reset, so this is consistent.
- Latency:
  - wire_in toggles before edge N.
  - Edge N: IDLE to SETTLE.
  - Edge N+1: push; tog_seen, count and ack_out update.
  - dout_valid rises after edge N+1 if the FIFO was empty.
- ack_out is registered and reflects tog_seen and count after the same edge that updates them.
- Pop latency: the pop takes effect at the edge where dout_valid && dout_ready; the next entry (or dout_valid = 0) is visible after that edge.
- Throughput: at most one accepted command every 2 cycles, which is limited by the host wire round-trip in practice.

## Configuration
- WIRE_CMD_STATS_EN:
  - Defined: stat_accepted is present and increments by 1 on every push. It wraps from 16'hFFFF to 0 and is cleared by reset.
  - Undefined: the stat_accepted port and its counter are absent.
- All other behaviour is identical either way.

## Test plan
- Single command:
  - Stimulus: after reset, wire_in = 32'h8000_1234.
  - Response: two edges later, dout = 31'h1234, dout_valid = 1, ack_out = 32'h8000_0001. A pop returns count to 0 and ack_out to 32'h8000_0000.
- Toggle glitch:
  - Stimulus: wire_in[31] goes 0→1→0 on consecutive cycles.
  - Response: no push, count = 0, ack_out[31] = 0.
- Full FIFO:
  - Stimulus: DEPTH = 8, dout_ready = 0, 9 alternating-toggle commands, each issued after its ack.
  - Response: 8 are accepted and count = 8. The 9th is held in WAIT_SPACE with ack_out[31] unchanged. One pop leads to the 9th being pushed one cycle later, with count = 8 and ack_out[31] flipped.
- Simultaneous push and pop:
  - Stimulus: count = 3, push and pop in the same cycle.
  - Response: count stays 3 and the payload order is preserved.
- Pointer wrap:
  - Stimulus: 20 commands with payloads 0..19, dout_ready = 1.
  - Response: output sequence is 0..19 in order, and stat_accepted = 20 with the macro defined.
- Reset mid-operation:
  - Stimulus: reset asserted with count = 5 while wire_in[31] = 1.
  - Response: outputs clear immediately. After reset deasserts, a push occurs two edges later, giving count = 1.
